vga_sync_decoder: RTL
=====================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001: i_clk  input  1  system clock (100 MHz); all state updates on its rising edge.
REQ-002: i_rst  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-003: i_pix_stb  input  1  25 MHz pixel strobe, one i_clk cycle wide; all sampling and counting happen only on cycles where it is 1.
REQ-004: i_hs  input  1  horizontal sync, active-low, synchronous to i_clk.
REQ-005: i_vs  input  1  vertical sync, active-low, synchronous to i_clk.
REQ-006: o_x  output  10  reconstructed pixel column, 0-639; holds 0 outside active area.
REQ-007: o_y  output  9  reconstructed pixel row, 0-479; holds 0 outside active area.
REQ-008: o_active  output  1  1 when (o_x,o_y) is a visible pixel and o_locked=1.
REQ-009: o_locked  output  1  1 while the decoder is locked to 800x525 timing.
REQ-010: o_frame_stb  output  1  one-i_clk pulse per decoded frame start.
REQ-011: o_err  output  1  one-i_clk pulse on a timing violation while locked.
REQ-012: o_err_cnt  output  8  saturating count of o_err pulses.

Function
REQ-013: Edge detection: i_hs and i_vs are registered on each strobe; a fall is prev=1, cur=0 at a strobe.
REQ-014: Horizontal counter hc (10 bit): on an hs fall hc<=0; otherwise on each strobe hc<=hc+1, saturating at 1023.
REQ-015: Line length check: at each hs fall, the measured length is hc+1; the required value is 800.
REQ-016: A vs fall sets flag vs_pend; it is cleared by the next hs fall.
REQ-017: Vertical counter vc (10 bit): on an hs fall, vc<=0 if vs_pend else vc+1, saturating at 1023.
REQ-018: Frame length check: the value vc+1 at an hs fall with vs_pend is the frame length; the required value is 525.
REQ-019: Active window: hc 144..783 and vc 35..514; o_x=hc-144 and o_y=vc-35, registered.
REQ-020: o_x, o_y and o_active lag the strobe that updates hc/vc by one i_clk.
REQ-021: FSM states are UNLOCKED, ACQUIRE and LOCKED.
REQ-022: UNLOCKED -> ACQUIRE at the first hs fall with vs_pend.
REQ-023: ACQUIRE -> LOCKED at the next frame start, provided every line in that frame measured 800 and the frame measured 525.
REQ-024: ACQUIRE -> UNLOCKED on any bad line length or bad frame length.
REQ-025: LOCKED -> UNLOCKED on any of: bad line length, bad frame length, hc reaching 1023, or vc reaching 1023.
REQ-026: On the LOCKED -> UNLOCKED transition, o_err pulses and o_err_cnt increments, holding at 255.
REQ-027: o_locked=1 exactly in LOCKED.
REQ-028: o_frame_stb pulses at each frame start (REQ-018 event) in every state.
REQ-029: A simultaneous hs fall and vs fall on the same strobe sets vs_pend first, so that hs fall is treated as the frame start.
REQ-030: On non-strobe cycles, all counters, flags and FSM state hold.

Reset
REQ-031: While i_rst=1, the decoder immediately forces: hc=0, vc=0, vs_pend=0, registered syncs=1, state UNLOCKED.
REQ-032: While i_rst=1, all outputs are 0, including o_err_cnt.
REQ-033: Reset asserted mid-frame aborts lock; after release, lock reacquires per REQ-022/023, which requires at least two frame starts.

Verification
REQ-034: Bench drives standard 640x480 timing from vga640x480 (hs low at h=16..111, vs low at lines 490..491) from reset -> o_locked=1 after the 2nd o_frame_stb, and o_err_cnt=0 after 10 frames.
REQ-035: Locked, check first visible pixel -> at h=160/line 0, o_x=0, o_y=0, o_active=1 one i_clk after the strobe.
REQ-036: Locked, check last visible pixel and blanking -> at h=799/line 479, o_x=639, o_y=479; at h=100, o_active=0.
REQ-037: Locked, one line shortened to 799 strobes -> o_err pulses once, o_err_cnt=1, o_locked=0, relock after 2 good frames.
REQ-038: Locked, i_hs held high for 1100 strobes -> hc saturates at 1023, o_err pulses, o_locked=0, no wrap.
REQ-039: Locked, i_rst pulsed mid-frame at line 200 -> all outputs 0 immediately; o_locked=1 again after 2 frame starts.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates and lock status from 800x525 VGA sync inputs
module vga_sync_decoder (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_active,
  output logic       o_locked,
  output logic       o_frame_stb,
  output logic       o_err,
  output logic [7:0] o_err_cnt
);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  state_t state_q, state_d;
  logic hs_q, vs_q, pend_q, pend_d, err_d;
  logic [9:0] hc_q, hc_d, vc_q, vc_d, x_q;
  logic [8:0] y_q;
  logic act_q, fs_q, err_q;
  logic [7:0] cnt_q;
  logic hs_fall, vs_fall, frame_start, bad, ovf, win;
  assign hs_fall = i_pix_stb && hs_q && !i_hs;
  assign vs_fall = i_pix_stb && vs_q && !i_vs;
  assign frame_start = hs_fall && (pend_q || vs_fall);
  assign bad = (hs_fall && hc_q != 10'd799) || (frame_start && vc_q != 10'd524);
  assign ovf = i_pix_stb && ((&hc_q) || (&vc_q));
  assign win = hc_q >= 10'd144 && hc_q <= 10'd783 && vc_q >= 10'd35 && vc_q <= 10'd514;
  always_comb begin
    hc_d = hs_fall ? '0 : (i_pix_stb && !(&hc_q)) ? hc_q + 10'd1 : hc_q;
    vc_d = frame_start ? '0 : (hs_fall && !(&vc_q)) ? vc_q + 10'd1 : vc_q;
    pend_d = !hs_fall && (vs_fall || pend_q);
    state_d = state_q;
    err_d = 1'b0;
    case (state_q)
      UNLOCKED: state_d = frame_start ? ACQUIRE : UNLOCKED;
      ACQUIRE:  state_d = bad ? UNLOCKED : frame_start ? LOCKED : ACQUIRE;
      LOCKED: begin
        err_d = bad || ovf;
        state_d = err_d ? UNLOCKED : LOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      pend_q  <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      state_q <= UNLOCKED;
      x_q     <= '0;
      y_q     <= '0;
      act_q   <= 1'b0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (i_pix_stb) begin
        hs_q <= i_hs;
        vs_q <= i_vs;
      end
      pend_q  <= pend_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      state_q <= state_d;
      fs_q    <= frame_start;
      err_q   <= err_d;
      cnt_q   <= cnt_q + {7'd0, err_d && !(&cnt_q)};
      // coordinates are taken from the already-updated counters, one clock behind the strobe
      x_q     <= win ? hc_q - 10'd144 : '0;
      y_q     <= win ? vc_q[8:0] - 9'd35 : '0;
      act_q   <= win && state_q == LOCKED;
    end
  end
  assign o_x = x_q;
  assign o_y = y_q;
  assign o_active = act_q;
  assign o_locked = state_q == LOCKED;
  assign o_frame_stb = fs_q;
  assign o_err = err_q;
  assign o_err_cnt = cnt_q;
endmodule
